// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: instruction-memory read port, decode output slot and execute redirect.
// master = fetch_controller side, slave = memory/decode/execute side.
interface fetch_controller_if;
    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_instr;
    logic               imem_inv_addr;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_instr, imem_inv_addr, if_ready,
        output imem_pc, if_valid, if_instr, if_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_instr, imem_inv_addr, if_ready,
        input  imem_pc, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/fetch_controller.sv
// Program-counter sequencer: one fetch per cycle into a one-entry valid/ready slot,
// with execute redirects and a sticky stop on invalid instruction addresses.
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    fetch_controller_if.master    bus,
    output logic                  fault,
    output logic [63:0]           fault_pc,
    output logic [31:0]           fetch_count
);
    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic               fault_q, fault_d;
    logic [PC_W-1:0]    fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic               slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Redirect beats fault beats load; a full, unaccepted slot stalls everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;
        slot_free     = !if_valid_q || bus.if_ready;

        case (state_q)
            ST_IDLE: begin
                if_valid_d = 1'b0;
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                end
            end
            ST_FETCH: begin
                if (bus.redirect_valid) begin
                    pc_d       = bus.redirect_pc;
                    if_valid_d = 1'b0;
                end else if (slot_free) begin
                    if (bus.imem_inv_addr) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                        if_valid_d = 1'b0;
                    end else begin
                        if_instr_d    = bus.imem_instr;
                        if_pc_d       = pc_q;
                        if_valid_d    = 1'b1;
                        pc_d          = pc_q + PC_W'(4);
                        fetch_count_d = fetch_count_q + CNT_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                if_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_pc  = pc_q;
    assign bus.if_valid = if_valid_q;
    assign bus.if_instr = if_instr_q;
    assign bus.if_pc    = if_pc_q;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;
    assign fetch_count  = fetch_count_q;

endmodule
